// File: rtl/rst_seq_lx45_pkg.sv
// Shared constants for the staged board reset sequencer.
// Fast-sim values are selected in the top when RST_SEQ_FAST_SIM_EN is defined.
package rst_seq_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] HOLD      = 2'd1;
    localparam logic [1:0] STAGE     = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam int unsigned FAST_HOLD = 255;
    localparam int unsigned FAST_GAP  = 16;
    localparam int unsigned FAST_DEB  = 4;

    localparam int unsigned RCNT_W = 8;

endpackage

// File: rtl/rst_seq_lx45_if.sv
// Board-side signal bundle of the reset sequencer: lock/button in, per-domain resets out.
interface rst_seq_lx45_if
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH = 3
);

    logic              dcm_locked;
    logic              button;
    logic [NUM_CH-1:0] reset;
    logic              seq_done;
    logic [RCNT_W-1:0] restart_cnt;

    modport master (
        input  dcm_locked,
        input  button,
        output reset,
        output seq_done,
        output restart_cnt
    );

    modport slave (
        output dcm_locked,
        output button,
        input  reset,
        input  seq_done,
        input  restart_cnt
    );

endinterface

// File: rtl/rst_seq_lx45_btn_debounce.sv
// Pushbutton synchroniser and debouncer: deb_btn follows the synchronised
// button only after it has differed from deb_btn for DEB_CYCLES consecutive cycles.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1023
) (
    input  logic sysclk,
    input  logic dcm_reset_n,
    input  logic button,
    output logic deb_btn
);

    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          btn_s1;
    logic          btn_s;
    logic [DW-1:0] cnt;

    always_ff @(posedge sysclk or negedge dcm_reset_n) begin
        if (!dcm_reset_n) begin
            btn_s1  <= 1'b0;
            btn_s   <= 1'b0;
            deb_btn <= 1'b0;
            cnt     <= '0;
        end else begin
            btn_s1 <= button;
            btn_s  <= btn_s1;
            if (btn_s == deb_btn) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYCLES - 1)) begin
                deb_btn <= btn_s;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_seq_lx45.sv
// Staged reset sequencer: holds all domains after DCM lock, then releases them in ascending order.
// RST_SEQ_FAST_SIM_EN overrides hold/gap/debounce lengths with short simulation values.
module rst_seq_lx45
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned HOLD_CYCLES = 4095,
    parameter int unsigned STAGE_GAP   = 256,
    parameter int unsigned DEB_CYCLES  = 1023,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           sysclk,
    input  logic           dcm_reset_n,
    rst_seq_lx45_if.master bus
);

`ifdef RST_SEQ_FAST_SIM_EN
    localparam int unsigned HOLD_EFF = FAST_HOLD;
    localparam int unsigned GAP_EFF  = FAST_GAP;
    localparam int unsigned DEB_EFF  = FAST_DEB;
`else
    localparam int unsigned HOLD_EFF = HOLD_CYCLES;
    localparam int unsigned GAP_EFF  = STAGE_GAP;
    localparam int unsigned DEB_EFF  = DEB_CYCLES;
`endif

    logic              lock_s1, lock_s, deb_btn, restart;
    logic [1:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [2:0]        idx, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              done_q, done_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;

    btn_debounce #(
        .DEB_CYCLES(DEB_EFF)
    ) u_deb (
        .sysclk     (sysclk),
        .dcm_reset_n(dcm_reset_n),
        .button     (bus.button),
        .deb_btn    (deb_btn)
    );

    // Leaving WAIT_LOCK requires lock_s=1 and deb_btn=0, so a bad level here
    // is always a fresh lock fall or button rise; both at once is one restart.
    assign restart = (state != WAIT_LOCK) && (!lock_s || deb_btn);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        rst_d   = rst_q;
        done_d  = done_q;
        rcnt_d  = rcnt_q;
        if (restart) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
            if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_d  = '1;
                    done_d = 1'b0;
                    if (lock_s && !deb_btn) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_EFF - 1)) begin
                        state_d  = STAGE;
                        cnt_d    = '0;
                        idx_d    = '0;
                        rst_d[0] = 1'b0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                STAGE: begin
                    if (idx == 3'(NUM_CH - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else if (cnt == CNT_W'(GAP_EFF - 1)) begin
                        cnt_d = '0;
                        idx_d = idx + 3'd1;
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (3'(i) == idx_d) rst_d[i] = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    rst_d  = '0;
                    done_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge dcm_reset_n) begin
        if (!dcm_reset_n) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            lock_s1 <= bus.dcm_locked;
            lock_s  <= lock_s1;
            state   <= state_d;
            cnt     <= cnt_d;
            idx     <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign bus.reset       = rst_q;
    assign bus.seq_done    = done_q;
    assign bus.restart_cnt = rcnt_q;

endmodule

// File: tb/tb_rst_seq_lx45.sv
// Directed + random bench for rst_seq_lx45 against a release-time reference model.
module tb_rst_seq_lx45;

    localparam int N      = 3;
    localparam int HOLD_P = 50;
    localparam int GAP_P  = 10;
    localparam int DEB_P  = 4;
`ifdef RST_SEQ_FAST_SIM_EN
    localparam int H = 255;
    localparam int G = 16;
    localparam int D = 4;
`else
    localparam int H = HOLD_P;
    localparam int G = GAP_P;
    localparam int D = DEB_P;
`endif
    localparam int SEQ_LEN = H + 2 * G + 20;

    logic sysclk = 1'b0;
    logic dcm_reset_n;
    always #5 sysclk = ~sysclk;

    rst_seq_lx45_if #(.NUM_CH(N)) bus ();

    rst_seq_lx45 #(
        .NUM_CH     (N),
        .HOLD_CYCLES(HOLD_P),
        .STAGE_GAP  (GAP_P),
        .DEB_CYCLES (DEB_P),
        .CNT_W      (16)
    ) dut (
        .sysclk     (sysclk),
        .dcm_reset_n(dcm_reset_n),
        .bus        (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference: synchroniser pipelines, debounce run length, and time since hold start.
    bit m_lock_s1, m_lock_s, m_btn_s1, m_btn_s, m_deb, m_active;
    int m_run, m_t, m_rcnt;

    task automatic model_reset();
        m_lock_s1 = 0; m_lock_s = 0; m_btn_s1 = 0; m_btn_s = 0; m_deb = 0;
        m_active = 0; m_run = 0; m_t = 0; m_rcnt = 0;
    endtask

    task automatic model_step();
        if (!dcm_reset_n) begin
            model_reset();
        end else begin
            if (m_active && (!m_lock_s || m_deb)) begin
                m_active = 0;
                if (m_rcnt < 255) m_rcnt++;
            end else if (m_active) begin
                m_t++;
            end else if (m_lock_s && !m_deb) begin
                m_active = 1;
                m_t = 0;
            end
            if (m_btn_s != m_deb) begin
                m_run++;
                if (m_run == D) begin
                    m_deb = m_btn_s;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_btn_s  = m_btn_s1;
            m_btn_s1 = bus.button;
            m_lock_s  = m_lock_s1;
            m_lock_s1 = bus.dcm_locked;
        end
    endtask

    function automatic logic [N-1:0] exp_reset();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !m_active || (m_t < H + i * G);
        return r;
    endfunction

    task automatic check_model(string tag);
        logic [N-1:0] er;
        logic ed;
        er = exp_reset();
        ed = m_active && (m_t >= H + (N - 1) * G + 1);
        n_assert++;
        assert (bus.reset === er) else begin
            n_fail++;
            $error("FAIL %s reset observed=%b expected=%b", tag, bus.reset, er);
        end
        n_assert++;
        assert (bus.seq_done === ed) else begin
            n_fail++;
            $error("FAIL %s seq_done observed=%b expected=%b", tag, bus.seq_done, ed);
        end
        n_assert++;
        assert (bus.restart_cnt === 8'(m_rcnt)) else begin
            n_fail++;
            $error("FAIL %s restart_cnt observed=%0d expected=%0d", tag, bus.restart_cnt, m_rcnt);
        end
    endtask

    task automatic check_const(string tag, logic [N-1:0] r, logic d, logic [7:0] c);
        n_assert++;
        assert (bus.reset === r && bus.seq_done === d && bus.restart_cnt === c) else begin
            n_fail++;
            $error("FAIL %s observed reset=%b done=%b cnt=%0d expected reset=%b done=%b cnt=%0d",
                   tag, bus.reset, bus.seq_done, bus.restart_cnt, r, d, c);
        end
    endtask

    task automatic check_int(string tag, int obs, int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(int n, string tag);
        repeat (n) begin
            @(posedge sysclk);
            model_step();
            @(negedge sysclk);
            check_model(tag);
        end
    endtask

    initial begin
        int t0, t1, t2, td, k_found;
        dcm_reset_n    = 1'b0;
        bus.dcm_locked = 1'b1;
        bus.button     = 1'b0;
        model_reset();
        tick(10, "por");
        check_const("por_state", '1, 1'b0, 8'd0);

        // Power-up: release times counted from reset deassertion (2 sync + 1 to enter HOLD).
        dcm_reset_n = 1'b1;
        t0 = -1; t1 = -1; t2 = -1; td = -1;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            tick(1, "powerup");
            if (t0 < 0 && !bus.reset[0]) t0 = k;
            if (t1 < 0 && !bus.reset[1]) t1 = k;
            if (t2 < 0 && !bus.reset[2]) t2 = k;
            if (td < 0 && bus.seq_done)  td = k;
        end
        check_int("rel0_time", t0, H + 3);
        check_int("rel1_time", t1, H + 3 + G);
        check_int("rel2_time", t2, H + 3 + 2 * G);
        check_int("done_time", td, H + 3 + 2 * G + 1);
        check_const("run_state", '0, 1'b1, 8'd0);

        bus.button = 1'b1;
        tick(3, "glitch");
        bus.button = 1'b0;
        tick(20, "glitch");
        check_const("glitch", '0, 1'b1, 8'd0);

        bus.button = 1'b1;
        tick(7, "press");
        check_const("press_latency", '1, 1'b0, 8'd1);
        tick(13, "press_hold");
        check_const("press_held", '1, 1'b0, 8'd1);
        bus.button = 1'b0;
        tick(SEQ_LEN, "repress");
        check_const("repress_run", '0, 1'b1, 8'd1);

        bus.dcm_locked = 1'b0;
        tick(5, "drop_run");
        bus.dcm_locked = 1'b1;
        k_found = 0;
        for (int k = 0; k < SEQ_LEN && k_found == 0; k++) begin
            tick(1, "to_stage");
            if (bus.reset === 3'b110) k_found = 1;
        end
        check_int("reach_stage", k_found, 1);
        bus.dcm_locked = 1'b0;
        tick(3, "lockloss");
        check_const("lockloss", '1, 1'b0, 8'd3);
        tick(20, "lockloss_wait");
        check_const("lockloss_held", '1, 1'b0, 8'd3);
        bus.dcm_locked = 1'b1;
        tick(SEQ_LEN, "relock");
        check_const("relock_run", '0, 1'b1, 8'd3);

        repeat (60) begin
            bus.button     = ($urandom_range(0, 3) == 0);
            bus.dcm_locked = ($urandom_range(0, 4) != 0);
            tick($urandom_range(1, 40), "random");
        end
        bus.button     = 1'b0;
        bus.dcm_locked = 1'b1;
        tick(SEQ_LEN, "random_settle");

        repeat (300) begin
            bus.dcm_locked = 1'b0;
            tick(4, "sat");
            bus.dcm_locked = 1'b1;
            tick(6, "sat");
        end
        n_assert++;
        assert (bus.restart_cnt === 8'd255) else begin
            n_fail++;
            $error("FAIL saturation restart_cnt observed=%0d expected=255", bus.restart_cnt);
        end
        tick(SEQ_LEN, "sat_run");
        check_const("sat_run", '0, 1'b1, 8'd255);

        @(posedge sysclk);
        #1 dcm_reset_n = 1'b0;
        #1 check_const("async_reset", '1, 1'b0, 8'd0);
        model_reset();
        #2 dcm_reset_n = 1'b1;
        tick(SEQ_LEN, "after_async");
        check_const("after_async", '0, 1'b1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
